reg_load_sequencer: RTL
=======================

Name: reg_load_sequencer

Overview:
- Sequences a 32-bit general-purpose register (FunSel/E/I interface) to load byte, halfword or word operands from a byte-wide memory.
- Issues byte reads with a variable-latency ack and assembles the operand big-endian.
- Drives the register's byte-load (100), shift-load (110), zero-extend-half (101) and sign-extend-half (111) operations.
- Sits between the control unit and one register plus the memory port.

Parameters:
- TIMEOUT_CYCLES, 16, max cycles waited for MemAck per byte (used only with LOAD_TIMEOUT_EN).

Ports:
- Clock  input  1  system clock, rising edge.
- Reset  input  1  asynchronous, active-low reset.
- Start  input  1  one-cycle load request; sampled only in IDLE.
- Size  input  2  00 byte, 01 halfword, 10 word, 11 illegal.
- Signed  input  1  sign-extend byte/halfword; ignored for word.
- Addr  input  32  base byte address; captured with Start.
- Busy  output  1  high from the cycle after an accepted Start until Done.
- Done  output  1  one-cycle pulse, load complete.
- Err  output  1  one-cycle pulse, illegal Size or timeout.
- MemAddr  output  32  byte address being read.
- MemRd  output  1  read request, held until MemAck.
- MemAck  input  1  read data valid this cycle.
- MemData  input  8  read byte.
- RegI  output  32  data to register I.
- RegFunSel  output  3  register function select.
- RegE  output  1  register enable.

Behaviour:
- Reset is asynchronous and active-low; the clock is Clock.
- All outputs are registered. Reset value of every output is 0, state is IDLE.
- Reset mid-operation: abort immediately, no further RegE, no Done.
- States: IDLE, REQ, WR, FIN.
- IDLE:
  - Start with Size 00/01/10: capture Addr, Size, Signed; idx=0; go to REQ.
  - Start with Size 11: Err pulse next cycle, stay IDLE, no memory or register activity.
  - Start while not IDLE is ignored.
- REQ:
  - MemRd=1, MemAddr=base+idx (32-bit wrap-around at 0xFFFFFFFF→0).
  - When MemAck=1: capture MemData into byte buffer b[idx], drop MemRd next cycle.
  - Halfword with idx=0: idx=1, stay in REQ (new address next cycle, MemRd deasserted for exactly one cycle between bytes).
  - Otherwise go to WR.
- WR (exactly one cycle, RegE=1):
  - Byte, unsigned: FunSel=100, I[7:0]=b0.
  - Byte, signed: FunSel=111, I[15:0]={{8{b0[7]}},b0}.
  - Halfword, unsigned: FunSel=101, I[15:0]={b0,b1}.
  - Halfword, signed: FunSel=111, I[15:0]={b0,b1}.
  - Word, idx=0: FunSel=100, I[7:0]=b.
  - Word, idx=1..3: FunSel=110, I[7:0]=b (register shifts left 8).
  - Unused RegI bits are driven 0.
  - Word with idx<3: idx++, go to REQ. Otherwise go to FIN.
- FIN: Done=1 for one cycle; Busy drops the same cycle; go to IDLE.
  - A Start is accepted in the cycle after FIN.
- RegE is 0 in every state except WR. RegFunSel/RegI hold their last values when RegE=0.
- Register write counts per load: byte 1, halfword 1, word 4.
- Final register value: byte = zero/sign-extended b0; half = zero/sign-extended {b0,b1}; word = {b0,b1,b2,b3}.
- MemAck outside REQ is ignored.

Optional Feature:
- LOAD_TIMEOUT_EN defined:
  - Per-byte counter starts at REQ entry.
  - If MemAck has not arrived after TIMEOUT_CYCLES cycles: drop MemRd and issue one RegE cycle with FunSel=011 (clear register).
  - Then pulse Err (not Done) and return to IDLE.
  - A MemAck arriving on the final allowed cycle still completes normally.
- Not defined: the sequencer waits indefinitely for MemAck, and Err only flags illegal Size.

Test Plan:
- Word load at Addr=0x100, memory bytes 0x12,0x34,0x56,0x78, Ack latency 1 → MemAddr 0x100..0x103, FunSel sequence 100,110,110,110, register=0x12345678, one Done, Busy 0 after.
- Signed byte at 0x20, byte 0x85 → single RegE with FunSel=111, RegI[15:0]=0xFF85, register=0xFFFFFF85.
- Unsigned half {0x80,0x01}, then signed half {0x80,0x01} → registers 0x00008001 and 0xFFFF8001, one RegE each, FunSel 101 then 111.
- Start with Size=11 → Err pulse, MemRd and RegE never assert; a Start while Busy during a word load is ignored and the word completes.
- Reset low during the third byte of a word load → outputs 0 immediately, no Done; a subsequent Start with Addr=0xFFFFFFFF and word size produces MemAddr 0xFFFFFFFF,0,1,2.
- With LOAD_TIMEOUT_EN and TIMEOUT_CYCLES=16, MemAck withheld → after 16 cycles MemRd=0, one RegE with FunSel=011, Err pulse, no Done.

Source files
------------

// File: rtl/reg_load_sequencer.sv
// Loads a byte, halfword or word operand from a byte-wide memory into a 32-bit register
// through its FunSel/E/I port. The optional MemAck timeout is enabled by LOAD_TIMEOUT_EN.
module reg_load_sequencer #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        Start,
    input  logic [1:0]  Size,
    input  logic        Signed,
    input  logic [31:0] Addr,
    output logic        Busy,
    output logic        Done,
    output logic        Err,
    output logic [31:0] MemAddr,
    output logic        MemRd,
    input  logic        MemAck,
    input  logic [7:0]  MemData,
    output logic [31:0] RegI,
    output logic [2:0]  RegFunSel,
    output logic        RegE
);

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned REG_W  = 32;
    localparam int unsigned BYTE_W = 8;
    localparam int unsigned FS_W   = 3;
    localparam int unsigned IDX_W  = 2;

    localparam logic [1:0] SZ_BYTE    = 2'b00;
    localparam logic [1:0] SZ_HALF    = 2'b01;
    localparam logic [1:0] SZ_WORD    = 2'b10;
    localparam logic [1:0] SZ_ILLEGAL = 2'b11;

    localparam logic [FS_W-1:0] FS_CLEAR      = 3'b011;
    localparam logic [FS_W-1:0] FS_LOAD_BYTE  = 3'b100;
    localparam logic [FS_W-1:0] FS_ZEXT_HALF  = 3'b101;
    localparam logic [FS_W-1:0] FS_SHIFT_LOAD = 3'b110;
    localparam logic [FS_W-1:0] FS_SEXT_HALF  = 3'b111;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WR,
        FIN
    } state_t;

    state_t              state;
    logic [ADDR_W-1:0]   base;
    logic [1:0]          size_q;
    logic                signed_q;
    logic [IDX_W-1:0]    idx;
    logic [BYTE_W-1:0]   first_byte;
    logic                tmo_q;
    logic                timeout_c;

    // Register command for the byte just acknowledged; {FunSel, I} packed together.
    function automatic logic [FS_W+REG_W-1:0] load_op(
        input logic [1:0]        sz,
        input logic              sgn,
        input logic [IDX_W-1:0]  i,
        input logic [BYTE_W-1:0] hi,
        input logic [BYTE_W-1:0] d
    );
        case (sz)
            SZ_BYTE: begin
                if (sgn) return {FS_SEXT_HALF, 16'd0, {BYTE_W{d[BYTE_W-1]}}, d};
                else     return {FS_LOAD_BYTE, 24'd0, d};
            end
            SZ_HALF: begin
                if (sgn) return {FS_SEXT_HALF, 16'd0, hi, d};
                else     return {FS_ZEXT_HALF, 16'd0, hi, d};
            end
            default: begin
                if (i == IDX_W'(0)) return {FS_LOAD_BYTE, 24'd0, d};
                else                return {FS_SHIFT_LOAD, 24'd0, d};
            end
        endcase
    endfunction

`ifdef LOAD_TIMEOUT_EN
    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [CNT_W-1:0] wait_cnt;

    // Counts cycles the current read has been outstanding; restarts for every byte.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            wait_cnt <= '0;
        end else if (state == REQ && MemRd && !MemAck) begin
            wait_cnt <= wait_cnt + CNT_W'(1);
        end else begin
            wait_cnt <= '0;
        end
    end

    assign timeout_c = (state == REQ) && MemRd && !MemAck &&
                       (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    // Without the timeout the sequencer waits for MemAck indefinitely.
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
    assign timeout_c          = 1'b0;
`endif

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state      <= IDLE;
            base       <= '0;
            size_q     <= '0;
            signed_q   <= 1'b0;
            idx        <= '0;
            first_byte <= '0;
            tmo_q      <= 1'b0;
            Busy       <= 1'b0;
            Done       <= 1'b0;
            Err        <= 1'b0;
            MemAddr    <= '0;
            MemRd      <= 1'b0;
            RegI       <= '0;
            RegFunSel  <= '0;
            RegE       <= 1'b0;
        end else begin
            Done <= 1'b0;
            Err  <= 1'b0;
            RegE <= 1'b0;
            case (state)
                IDLE: begin
                    if (Start) begin
                        if (Size == SZ_ILLEGAL) begin
                            Err <= 1'b1;
                        end else begin
                            base     <= Addr;
                            size_q   <= Size;
                            signed_q <= Signed;
                            idx      <= '0;
                            tmo_q    <= 1'b0;
                            MemAddr  <= Addr;
                            MemRd    <= 1'b1;
                            Busy     <= 1'b1;
                            state    <= REQ;
                        end
                    end
                end

                REQ: begin
                    if (!MemRd) begin
                        // Second halfword byte: read re-issued after the one-cycle gap.
                        MemRd <= 1'b1;
                    end else if (MemAck) begin
                        MemRd <= 1'b0;
                        if (size_q == SZ_HALF && idx == IDX_W'(0)) begin
                            first_byte <= MemData;
                            idx        <= IDX_W'(1);
                            MemAddr    <= base + ADDR_W'(1);
                        end else begin
                            RegE                <= 1'b1;
                            {RegFunSel, RegI}   <= load_op(size_q, signed_q, idx, first_byte, MemData);
                            state               <= WR;
                        end
                    end else if (timeout_c) begin
                        MemRd     <= 1'b0;
                        RegE      <= 1'b1;
                        RegFunSel <= FS_CLEAR;
                        RegI      <= '0;
                        tmo_q     <= 1'b1;
                        state     <= WR;
                    end
                end

                WR: begin
                    if (!tmo_q && size_q == SZ_WORD && idx != IDX_W'(3)) begin
                        idx     <= idx + IDX_W'(1);
                        MemAddr <= base + ADDR_W'(idx + IDX_W'(1));
                        MemRd   <= 1'b1;
                        state   <= REQ;
                    end else begin
                        Busy  <= 1'b0;
                        Done  <= !tmo_q;
                        Err   <= tmo_q;
                        state <= FIN;
                    end
                end

                FIN: begin
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
